alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter LAT, default 2, giving the ALU latency in clock cycles from operand/CTR presentation to valid O.
REQ-002 The block SHALL have port ck  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  instruction offered.
REQ-005 The block SHALL have port in_ready  output  1  instruction accepted when in_valid and in_ready are both high at a rising edge.
REQ-006 The block SHALL have port in_ld  input  1  1 = load-immediate, 0 = ALU operation.
REQ-007 The block SHALL have port in_op  input  4  ALU control code, ignored when in_ld=1.
REQ-008 The block SHALL have ports in_rd, in_rs, in_rt  input  2 each  destination, first-source and second-source register indices.
REQ-009 The block SHALL have port in_imm  input  8  immediate value for load.
REQ-010 The block SHALL have ports A, B  output  8 each  ALU operands, and CTR  output  4  ALU control.
REQ-011 The block SHALL have port O  input  8  ALU result.
REQ-012 The block SHALL have ports out_valid  output  1  one-cycle result strobe, out_data  output  8  written-back value, and out_err  output  1  undefined-opcode flag qualified by out_valid.

Function
REQ-013 The block SHALL hold a register file of four 8-bit registers R0-R3.
REQ-014 The block SHALL implement states IDLE, ISSUE, WAIT and DONE; in_ready SHALL be high only in IDLE and not during rst.
REQ-015 In IDLE, an accepted in_ld=1 instruction SHALL write in_imm to R[in_rd] at the accepting edge, with no state change and no out_valid.
REQ-016 In IDLE, an accepted in_ld=0 instruction SHALL latch in_op/rd/rs/rt and move to ISSUE at the accepting edge.
REQ-017 On entry to ISSUE, the block SHALL drive A=R[rs], B=R[rt], CTR=op from registers, held constant through ISSUE and WAIT.
REQ-018 ISSUE SHALL last one cycle, then WAIT SHALL last exactly LAT cycles, counted by an internal counter.
REQ-019 At the edge ending the last WAIT cycle, the block SHALL write O into R[rd], load out_data with O, set out_valid, and enter DONE.
REQ-020 DONE SHALL last one cycle with out_valid=1, then return to IDLE; out_valid SHALL be 0 in every other cycle.
REQ-021 With LAT=2, from an accepting edge t the sequence SHALL be ISSUE t..t+1, WAIT t+1..t+3, writeback at t+3, out_valid high t+3..t+4, in_ready high again from t+4.
REQ-022 out_err SHALL be 1 with out_valid when the op is 0010-0111; the value written back is whatever O returns (0 from the ALU).
REQ-023 Operands SHALL be read at ISSUE entry; rd equal to rs or rt SHALL overwrite the source only at writeback.
REQ-024 in_valid while in_ready=0 SHALL be ignored with no side effects; the offering side SHALL hold the instruction.
REQ-025 After DONE, A, B and CTR SHALL retain their last values until the next ISSUE.
REQ-026 All arithmetic SHALL be 8-bit modulo, inherited from O; the block SHALL perform no arithmetic of its own except the WAIT counter.

Reset
REQ-027 rst SHALL force IDLE, R0-R3=0, A=0, B=0, CTR=0, out_data=0, out_valid=0, out_err=0 and WAIT counter=0 at the next rising edge.
REQ-028 rst asserted in ISSUE, WAIT or DONE SHALL abort the operation with no register-file write and no out_valid.
REQ-029 rst SHALL take priority over a simultaneous accepted instruction, which SHALL be dropped.

Verification
REQ-030 Load R0=0x05 and R1=0x03, then add (op 0000, rd=2, rs=0, rt=1) -> out_valid 3 cycles after acceptance, out_data=0x08, R2=0x08, out_err=0.
REQ-031 With R0=0x03 and R1=0x05, subtract (op 0001, rd=0, rs=0, rt=1) -> out_data=0xFE, R0=0xFE; rotate-left (op 1111) of 0x81 -> 0x03.
REQ-032 Issue op 0100 -> out_err=1, out_data=0x00, rd written 0.
REQ-033 Hold in_valid during WAIT with in_ld=1, imm=0xAA -> nothing written until IDLE, then exactly one write of 0xAA.
REQ-034 Assert rst in the second WAIT cycle -> no out_valid, R0-R3=0, in_ready=1 the cycle after reset is released.
REQ-035 Run back-to-back ops with in_valid held high -> one acceptance per LAT+3 cycles and results matching a reference model.

Source files
------------

// File: rtl/alu_seq.sv
// Register-file sequencer for an external ALU with a fixed result latency.
// It loads immediates, issues operands and control to the ALU, then writes the result back.
module alu_seq #(
    parameter int LAT = 2
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_ld,
    input  logic [3:0] in_op,
    input  logic [1:0] in_rd,
    input  logic [1:0] in_rs,
    input  logic [1:0] in_rt,
    input  logic [7:0] in_imm,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [3:0] CTR,
    input  logic [7:0] O,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_err
);

    // state | meaning
    // IDLE  | ready; loads complete here, ALU ops are accepted here
    // ISSUE | operands and control just presented to the ALU
    // WAIT  | counting down the ALU latency
    // DONE  | result written back, out_valid high
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [7:0]    rf [4];
    logic [1:0]    rd_q;
    logic          accept;
    logic          wb;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign wb       = (state == WAIT) && (cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !in_ld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wb) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_q      <= '0;
            A         <= '0;
            B         <= '0;
            CTR       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= wb;
            // Operands are captured from the register file at the accepting edge,
            // so a destination that aliases a source is only overwritten at writeback.
            if (accept) begin
                if (in_ld) begin
                    rf[in_rd] <= in_imm;
                end else begin
                    A    <= rf[in_rs];
                    B    <= rf[in_rt];
                    CTR  <= in_op;
                    rd_q <= in_rd;
                end
            end
            // WAIT spans LAT cycles: load LAT-1 and write back when the count hits zero.
            if (state == ISSUE) begin
                cnt <= CW'(LAT - 1);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (wb) begin
                rf[rd_q] <= O;
                out_data <= O;
                out_err  <= (CTR >= 4'd2) && (CTR <= 4'd7);
            end
        end
    end

endmodule
